// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner:
//   state_t    - scanner FSM states
//   KEY_MAP    - hex code of each key, indexed [row][column]
//   col_drive  - one-hot active-low column drive pattern for a column index
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Physical legend: row 3 carries E 0 F D, so the map is not a simple
  // row*4+col encoding.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/row_sync.sv
// ---------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for asynchronous, active-low row inputs. Flops reset
// to all-ones so an idle (pulled-up) keypad is seen during and after reset.
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   raw     - asynchronous input bus
//   synced  - input bus after two clk stages
// ---------------------------------------------------------------------------
module row_sync #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] synced
);

  logic [DATA_W-1:0] row_p0;
  logic [DATA_W-1:0] row_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_p0 <= '1;
      row_p1 <= '1;
    end else begin
      // stage 0: capture asynchronous input
      row_p0 <= raw;
      // stage 1: resolved, safe to use
      row_p1 <= row_p0;
    end
  end

  assign synced = row_p1;

endmodule

// File: rtl/keypad_scan_debounce.sv
// ---------------------------------------------------------------------------
// keypad_scan_debounce
// Scans a 4x4 matrix keypad one column at a time, debounces press and release
// of the first key found, and reports its hex code.
// Ports:
//   clk          - system clock (rising edge)
//   reset        - synchronous active-high reset
//   keypad_hori  - row inputs, active-low, asynchronous
//   keypad_vert  - column drive, one-hot active-low (registered)
//   key_value    - hex code of the last accepted key (registered, held)
//   key_valid    - one-cycle strobe when key_value updates (registered)
//   key_held     - high while the accepted key is still pressed (registered)
// Parameters:
//   SETTLE_CYCLES   - cycles each column is driven before rows are sampled
//   DEBOUNCE_CYCLES - cycles a press or release must be stable
// ---------------------------------------------------------------------------
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4800,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_hori,
  output logic [3:0] keypad_vert,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CYC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES
                                                             : DEBOUNCE_CYCLES;
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       row_s;
  logic             any_low;
  logic             row_high;

  row_sync #(
    .DATA_W(4)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .raw   (keypad_hori),
    .synced(row_s)
  );

  // Several rows low on one column: the lowest row index wins.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign any_low  = ~&row_s;
  assign row_high = row_s[row];

  // col is left untouched while a key is being tracked, so it doubles as the
  // latched column; keypad_vert only moves together with col.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      col         <= 2'd0;
      row         <= 2'd0;
      cnt         <= '0;
      keypad_vert <= 4'b1110;
      key_value   <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= '0;
            if (any_low) begin
              row   <= first_low(row_s);
              state <= DB_PRESS;
            end else begin
              col         <= col + 2'd1;
              keypad_vert <= col_drive(col + 2'd1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DB_PRESS: begin
          if (row_high) begin
            // bounce: give up on this key and move on
            state       <= SCAN;
            cnt         <= '0;
            col         <= col + 2'd1;
            keypad_vert <= col_drive(col + 2'd1);
          end else if (cnt == DEBOUNCE_LAST) begin
            key_value <= KEY_MAP[row][col];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (row_high) begin
            cnt   <= '0;
            state <= DB_RELEASE;
          end
        end

        DB_RELEASE: begin
          if (!row_high) begin
            // release bounce: still held, no new strobe
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEBOUNCE_LAST) begin
            state       <= SCAN;
            cnt         <= '0;
            key_held    <= 1'b0;
            col         <= col + 2'd1;
            keypad_vert <= col_drive(col + 2'd1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_debounce
// Bench for keypad_scan_debounce with a behavioural 4x4 key matrix: a row
// reads low when a pressed key sits on the currently driven column.
// ---------------------------------------------------------------------------
module tb_keypad_scan_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keypad_hori;
  logic [3:0] keypad_vert;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;  // [row][col]

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];
  logic prev_valid = 1'b0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  vert;
    logic        valid;
    logic        held;
  } vec_t;

  vec_t vecs[20];

  keypad_scan_debounce #(
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keypad_hori(keypad_hori),
    .keypad_vert(keypad_vert),
    .key_value  (key_value),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    keypad_hori = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && (keypad_vert[c] === 1'b0)) keypad_hori[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Strobe monitor: value against scoreboard, never two strobes in a row.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      check("no_back_to_back_valid", 32'(prev_valid), 32'd0);
      check("strobe_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("strobe_key_value", 32'(key_value), 32'(exp_q.pop_front()));
    end
    prev_valid <= key_valid;
  end

  task automatic wait_valid(input int bound, input string name);
    int i = 0;
    while (key_valid !== 1'b1 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (key_valid !== 1'b1) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_vert(input logic [3:0] v, input bit eq, input int bound, input string name);
    int i = 0;
    while (((keypad_vert === v) != eq) && i < bound) begin
      @(negedge clk);
      i++;
    end
    if ((keypad_vert === v) != eq) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_held_low(input int bound, input string name, output int cycles);
    cycles = 0;
    while (key_held !== 1'b0 && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
    if (key_held !== 1'b0) check(name, 32'd0, 32'd1);
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (key_valid === 1'b1) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq [5];
    int n;
    int t;
    bit ok;

    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int i = 0; i < 20; i++) begin
      vecs[i].keys  = 16'h0000;
      vecs[i].vert  = seq[i / 4];
      vecs[i].valid = 1'b0;
      vecs[i].held  = 1'b0;
    end

    pressed = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle scan straight out of reset
    check("reset_key_value", 32'(key_value), 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      pressed = vecs[i].keys;
      check($sformatf("idle_scan[%0d]", i), 32'({keypad_vert, key_valid, key_held}),
            32'({vecs[i].vert, vecs[i].valid, vecs[i].held}));
    end

    // Key 6 (row 1, column 2): press, hold, release
    pressed[1][2] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(200, "k6_strobe_timeout");
    check("k6_value", 32'(key_value), 32'h6);
    @(negedge clk);
    check("k6_held", 32'(key_held), 32'd1);
    count_valid(20, n);
    check("k6_single_strobe", 32'(n), 32'd0);
    check("k6_column_latched", 32'(keypad_vert), 32'b1011);
    pressed[1][2] = 1'b0;
    wait_held_low(60, "k6_release_timeout", t);
    check("k6_release_min_cycles", 32'(t >= 9), 32'd1);
    check("k6_resume_col3", 32'(keypad_vert), 32'b0111);

    // Key 1 with press bounce: low 3, high 1, then stays low
    wait_vert(4'b1110, 1'b0, 40, "k1_wait_leave_col0");
    wait_vert(4'b1110, 1'b1, 40, "k1_wait_col0");
    n = 0;
    pressed[0][0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (key_valid === 1'b1) n++;
    end
    pressed[0][0] = 1'b0;
    @(negedge clk);
    if (key_valid === 1'b1) n++;
    pressed[0][0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (key_valid === 1'b1) n++;
    end
    check("k1_no_bounce_strobe", 32'(n), 32'd0);
    exp_q.push_back(4'h1);
    wait_valid(200, "k1_strobe_timeout");
    check("k1_value", 32'(key_value), 32'h1);
    @(negedge clk);
    check("k1_held", 32'(key_held), 32'd1);

    // Release bounce while held: high 3, low 2, then high
    ok = 1'b1;
    n  = 0;
    pressed[0][0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ok &= (key_held === 1'b1);
      if (key_valid === 1'b1) n++;
    end
    pressed[0][0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ok &= (key_held === 1'b1);
      if (key_valid === 1'b1) n++;
    end
    pressed[0][0] = 1'b0;
    repeat (9) begin
      @(negedge clk);
      ok &= (key_held === 1'b1);
      if (key_valid === 1'b1) n++;
    end
    check("k1_release_bounce_held", 32'(ok), 32'd1);
    check("k1_release_no_strobe", 32'(n), 32'd0);
    wait_held_low(30, "k1_release_timeout", t);
    check("k1_resume_col1", 32'(keypad_vert), 32'b1101);

    // Rows 2 and 3 on column 1 together, then a second key while held
    pressed[2][1] = 1'b1;
    pressed[3][1] = 1'b1;
    exp_q.push_back(4'h8);
    wait_valid(200, "k8_strobe_timeout");
    check("k8_lowest_row", 32'(key_value), 32'h8);
    @(negedge clk);
    pressed[0][3] = 1'b1;
    count_valid(30, n);
    check("second_key_ignored", 32'(n), 32'd0);
    check("k8_still_held", 32'(key_held), 32'd1);
    check("k8_column_latched", 32'(keypad_vert), 32'b1101);
    pressed[2][1] = 1'b0;
    pressed[3][1] = 1'b0;
    exp_q.push_back(4'hA);
    wait_valid(200, "kA_strobe_timeout");
    check("kA_value", 32'(key_value), 32'hA);
    pressed[0][3] = 1'b0;
    wait_held_low(60, "kA_release_timeout", t);

    // Reset in the middle of debouncing a press of key 9
    wait_vert(4'b1011, 1'b0, 40, "k9_wait_leave_col2");
    pressed[2][2] = 1'b1;
    wait_vert(4'b1011, 1'b1, 40, "k9_wait_col2");
    count_valid(6, n);
    check("k9_no_early_strobe", 32'(n), 32'd0);
    reset   = 1'b1;
    pressed = '0;
    @(negedge clk);
    check("midreset_vert", 32'(keypad_vert), 32'b1110);
    check("midreset_value", 32'(key_value), 32'h0);
    check("midreset_valid", 32'(key_valid), 32'd0);
    check("midreset_held", 32'(key_held), 32'd0);
    reset = 1'b0;
    count_valid(20, n);
    check("midreset_no_strobe", 32'(n), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4800, clk cycles each column is driven before rows are sampled (100 us at 48 MHz).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 960000, clk cycles a press or release must be stable (20 ms at 48 MHz).
REQ-003 SHALL have port clk  input  1  single 48 MHz system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port keypad_hori  input  4  asynchronous row inputs, active-low (pulled up), bit r = row r.
REQ-006 SHALL have port keypad_vert  output  4  column drive, one-hot active-low, bit c = column c.
REQ-007 SHALL have port key_value  output  4  hex code of the last accepted key, held until the next accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle strobe when key_value updates.
REQ-009 SHALL have port key_held  output  1  high while an accepted key is still pressed.

Function
REQ-010 SHALL pass keypad_hori through a 2-flop synchronizer (row_s); all decisions use row_s only.
REQ-011 SHALL implement FSM states SCAN, DB_PRESS, HELD and DB_RELEASE, plus a column index col (0-3) and one cycle counter sized by $clog2 of the larger parameter.
REQ-012 SCAN: drive column col low; count SETTLE_CYCLES; on terminal count, if any row_s bit is 0, latch col and the lowest-index low row, clear counter, go DB_PRESS; else col <= col+1 (3 wraps to 0), clear counter.
REQ-013 DB_PRESS: keep latched column driven; if latched row_s bit reads 1, go SCAN with col+1 and no strobe; after DEBOUNCE_CYCLES consecutive low cycles, load key_value, pulse key_valid for exactly 1 cycle, go HELD.
REQ-014 HELD: keep latched column driven; when latched row_s bit reads 1, clear counter, go DB_RELEASE.
REQ-015 DB_RELEASE: if latched row_s bit reads 0, return to HELD with no new strobe (bounce); after DEBOUNCE_CYCLES consecutive high cycles, go SCAN with col+1.
REQ-016 key_held SHALL be 1 exactly in HELD and DB_RELEASE.
REQ-017 Keys pressed on other rows or columns while not in SCAN SHALL be ignored; no strobe for them until they are rescanned after release.
REQ-018 Simultaneous lows on several rows of one column SHALL select the lowest row index.
REQ-019 Key map (row r, column c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = E 0 F D.
REQ-020 key_valid SHALL never be asserted on two consecutive cycles.

Reset
REQ-021 On reset: state SCAN, col 0, keypad_vert = 4'b1110, key_value = 0, key_valid = 0, key_held = 0, counter 0, synchronizer flops = 4'b1111.
REQ-022 Reset asserted in any state SHALL abort the operation with no key_valid pulse on that or the following cycle.

Structure
REQ-023 Package keypad_pkg SHALL hold the state enum typedef and the 4x4 key map constant.
REQ-024 A single sub-module, row_sync (parameterised-width 2-flop synchronizer), SHALL implement REQ-010.
REQ-025 Outputs keypad_vert, key_value, key_valid and key_held SHALL be registered.

Verification (bench: SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-026 Idle after reset, rows 4'b1111 -> keypad_vert cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; key_valid stays 0.
REQ-027 Row 1 held low whenever column 2 is driven, stable 20 cycles -> exactly one key_valid, key_value = 4'h6, key_held = 1; release and stay high 8+ cycles -> key_held = 0, scanning resumes at column 3.
REQ-028 Press bounce (row 0 on column 0 low 3 cycles, high 1, low 12) -> no strobe for the bounce; exactly one strobe with key_value = 4'h1 after the final stable low.
REQ-029 Release bounce while HELD (high 3 cycles, low 2, high 10) -> no second strobe; key_held stays 1 until the final 8-cycle high run completes.
REQ-030 Column 1 rows 2 and 3 low together -> key_value = 4'h8; a second key on column 3 pressed while HELD -> ignored until the first key is released.
REQ-031 Reset pulsed mid-DB_PRESS -> outputs at REQ-021 values the next cycle; no key_valid pulse.
